// File: rtl/pls_seg_writer.sv
// Pulse-segment producer: expands one motion command into a framed stream of
// step words with a saturating linear period ramp, written into the pls_cont FIFO.
module pls_seg_writer #(
   parameter int T_WIDTH = 32,
   parameter int N_WIDTH = 32,
   parameter int T_MIN   = 8
) (
   input  logic               clk,
   input  logic               aclr,
   input  logic               abort,
   input  logic               brake_clk,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_dir,
   input  logic [T_WIDTH-1:0] cmd_T,
   input  logic [T_WIDTH-1:0] cmd_dT,
   input  logic [N_WIDTH-1:0] cmd_N,
   output logic               sop,
   output logic               eop,
   output logic               pls_mask,
   output logic               pls_dir,
   output logic [T_WIDTH-1:0] pls_T,
   output logic               wrreq,
   input  logic               full,
   output logic               busy,
   output logic [N_WIDTH-1:0] steps_left,
   output logic               done,
   output logic               err
);

   // state | meaning
   // IDLE  | no segment; ready for a command, word outputs held at 0
   // EMIT  | presenting a word; written on any cycle with wrreq=1
   typedef enum logic {IDLE, EMIT} state_t;

   localparam logic [T_WIDTH-1:0]        T_MIN_V = T_WIDTH'(T_MIN);
   localparam logic signed [T_WIDTH+1:0] SUM_MIN = (T_WIDTH+2)'(T_MIN);
   localparam logic signed [T_WIDTH+1:0] SUM_MAX = {2'b00, {T_WIDTH{1'b1}}};

   state_t               state;
   logic [T_WIDTH-1:0]   dt_r;
   logic [T_WIDTH-1:0]   t_first;
   logic [T_WIDTH-1:0]   t_next;
   logic signed [T_WIDTH+1:0] t_sum;

   assign cmd_ready = (state == IDLE) && !abort && !brake_clk;
   assign wrreq     = (state == EMIT) && !full && !abort && !brake_clk;

   assign t_first = (cmd_T < T_MIN_V) ? T_MIN_V : cmd_T;

   // Two guard bits: an unsigned T plus a signed dT can exceed the positive
   // range of a single-guard-bit signed sum near the top of the T range.
   assign t_sum = $signed({2'b00, pls_T}) + $signed({{2{dt_r[T_WIDTH-1]}}, dt_r});

   always_comb begin
      t_next = t_sum[T_WIDTH-1:0];
      if (t_sum < SUM_MIN)
         t_next = T_MIN_V;
      else if (t_sum > SUM_MAX)
         t_next = {T_WIDTH{1'b1}};
   end

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         state      <= IDLE;
         dt_r       <= '0;
         sop        <= 1'b0;
         eop        <= 1'b0;
         pls_mask   <= 1'b0;
         pls_dir    <= 1'b0;
         pls_T      <= '0;
         busy       <= 1'b0;
         steps_left <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort || brake_clk) begin
            state      <= IDLE;
            sop        <= 1'b0;
            eop        <= 1'b0;
            pls_mask   <= 1'b0;
            pls_dir    <= 1'b0;
            pls_T      <= '0;
            busy       <= 1'b0;
            steps_left <= '0;
            if (abort)
               err <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (cmd_valid) begin
                     state      <= EMIT;
                     dt_r       <= cmd_dT;
                     sop        <= 1'b1;
                     eop        <= (cmd_N <= N_WIDTH'(1));
                     pls_mask   <= (cmd_N != '0);
                     pls_dir    <= cmd_dir;
                     pls_T      <= t_first;
                     busy       <= 1'b1;
                     steps_left <= (cmd_N == '0) ? N_WIDTH'(1) : cmd_N;
                     err        <= 1'b0;
                  end
               end
               EMIT: begin
                  if (!full) begin
                     if (steps_left > N_WIDTH'(1)) begin
                        steps_left <= steps_left - N_WIDTH'(1);
                        sop        <= 1'b0;
                        eop        <= (steps_left == N_WIDTH'(2));
                        pls_T      <= t_next;
                     end else begin
                        state      <= IDLE;
                        done       <= 1'b1;
                        sop        <= 1'b0;
                        eop        <= 1'b0;
                        pls_mask   <= 1'b0;
                        pls_dir    <= 1'b0;
                        pls_T      <= '0;
                        busy       <= 1'b0;
                        steps_left <= '0;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pls_seg_writer.sv
// Directed bench for pls_seg_writer with an 8-bit period field.
module tb_pls_seg_writer;

   logic       clk = 1'b0;
   logic       aclr, abort, brake_clk, cmd_valid, cmd_ready, cmd_dir;
   logic [7:0] cmd_T, cmd_dT, cmd_N;
   logic       sop, eop, pls_mask, pls_dir, wrreq, full, busy, done, err;
   logic [7:0] pls_T, steps_left;

   int checks = 0;
   int errors = 0;

   pls_seg_writer #(.T_WIDTH(8), .N_WIDTH(8), .T_MIN(8)) dut (
      .clk(clk), .aclr(aclr), .abort(abort), .brake_clk(brake_clk),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
      .cmd_T(cmd_T), .cmd_dT(cmd_dT), .cmd_N(cmd_N),
      .sop(sop), .eop(eop), .pls_mask(pls_mask), .pls_dir(pls_dir),
      .pls_T(pls_T), .wrreq(wrreq), .full(full), .busy(busy),
      .steps_left(steps_left), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic            dir;
      logic [7:0]      t;
      logic [7:0]      dt;
      logic [7:0]      n;
      logic [2:0]      nw;
      logic            mask;
      logic [3:0][7:0] et;   // {word3, word2, word1, word0}
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic issue(input logic d, input logic [7:0] t, input logic [7:0] dt, input logic [7:0] n);
      cmd_dir = d; cmd_T = t; cmd_dT = dt; cmd_N = n; cmd_valid = 1'b1;
      #1;
      chk("cmd_ready_before_accept", cmd_ready, 1'b1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic word(input logic s, input logic e, input logic m, input logic d,
                       input logic [7:0] t, input logic [7:0] sl);
      chk("wrreq", wrreq, 1'b1);
      chk("sop", sop, s);
      chk("eop", eop, e);
      chk("mask", pls_mask, m);
      chk("dir", pls_dir, d);
      chk("pls_T", pls_T, t);
      chk("steps_left", steps_left, sl);
      chk("busy", busy, 1'b1);
      @(posedge clk); #1;
   endtask

   task automatic seg_end();
      chk("done_pulse", done, 1'b1);
      chk("busy_end", busy, 1'b0);
      chk("ready_end", cmd_ready, 1'b1);
      chk("T_cleared", pls_T, 8'd0);
      chk("steps_cleared", steps_left, 8'd0);
   endtask

   initial begin
      vecs[0] = '{1'b1, 8'd100, 8'd0,   8'd3, 3'd3, 1'b1, {8'd0,   8'd100, 8'd100, 8'd100}};
      vecs[1] = '{1'b0, 8'd50,  8'd0,   8'd0, 3'd1, 1'b0, {8'd0,   8'd0,   8'd0,   8'd50}};
      vecs[2] = '{1'b1, 8'd20,  8'hFB,  8'd4, 3'd4, 1'b1, {8'd8,   8'd10,  8'd15,  8'd20}};
      vecs[3] = '{1'b0, 8'd250, 8'd10,  8'd3, 3'd3, 1'b1, {8'd0,   8'd255, 8'd255, 8'd250}};
      vecs[4] = '{1'b1, 8'd3,   8'd0,   8'd1, 3'd1, 1'b1, {8'd0,   8'd0,   8'd0,   8'd8}};
      vecs[5] = '{1'b0, 8'd2,   8'd5,   8'd0, 3'd1, 1'b0, {8'd0,   8'd0,   8'd0,   8'd8}};
      vecs[6] = '{1'b1, 8'd200, 8'h80,  8'd4, 3'd4, 1'b1, {8'd8,   8'd8,   8'd72,  8'd200}};

      aclr = 1'b1; abort = 1'b0; brake_clk = 1'b0; cmd_valid = 1'b0; full = 1'b0;
      cmd_dir = 1'b0; cmd_T = '0; cmd_dT = '0; cmd_N = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", cmd_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_wrreq", wrreq, 1'b0);
      chk("rst_T", pls_T, 8'd0);
      chk("rst_steps", steps_left, 8'd0);
      chk("rst_flags", {sop, eop, pls_mask, pls_dir, done, err}, 6'd0);
      aclr = 1'b0;
      @(posedge clk); #1;

      // Table vectors, issued back-to-back
      for (int v = 0; v < 7; v++) begin
         issue(vecs[v].dir, vecs[v].t, vecs[v].dt, vecs[v].n);
         for (int k = 0; k < int'(vecs[v].nw); k++)
            word(k == 0, k == int'(vecs[v].nw) - 1, vecs[v].mask, vecs[v].dir,
                 vecs[v].et[k], (vecs[v].n == 0) ? 8'd1 : vecs[v].n - 8'(k));
         seg_end();
      end
      @(posedge clk); #1;
      chk("done_one_cycle", done, 1'b0);

      // FIFO full stall after word 2
      issue(1'b0, 8'd30, 8'd1, 8'd5);
      word(1'b1, 1'b0, 1'b1, 1'b0, 8'd30, 8'd5);
      word(1'b0, 1'b0, 1'b1, 1'b0, 8'd31, 8'd4);
      full = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("full_wrreq", wrreq, 1'b0);
         chk("full_T_held", pls_T, 8'd32);
         chk("full_steps_held", steps_left, 8'd3);
         @(posedge clk); #1;
      end
      full = 1'b0;
      #1;
      word(1'b0, 1'b0, 1'b1, 1'b0, 8'd32, 8'd3);
      word(1'b0, 1'b0, 1'b1, 1'b0, 8'd33, 8'd2);
      word(1'b0, 1'b1, 1'b1, 1'b0, 8'd34, 8'd1);
      seg_end();

      // Abort during word 3 of 10
      issue(1'b1, 8'd40, 8'd0, 8'd10);
      word(1'b1, 1'b0, 1'b1, 1'b1, 8'd40, 8'd10);
      word(1'b0, 1'b0, 1'b1, 1'b1, 8'd40, 8'd9);
      abort = 1'b1;
      #1;
      chk("abort_wrreq", wrreq, 1'b0);
      chk("abort_ready", cmd_ready, 1'b0);
      @(posedge clk); #1;
      abort = 1'b0;
      #1;
      chk("abort_err", err, 1'b1);
      chk("abort_busy", busy, 1'b0);
      chk("abort_no_done", done, 1'b0);
      chk("abort_steps", steps_left, 8'd0);
      @(posedge clk); #1;
      chk("abort_no_done_late", done, 1'b0);
      issue(1'b0, 8'd60, 8'd0, 8'd1);
      chk("err_cleared", err, 1'b0);
      word(1'b1, 1'b1, 1'b1, 1'b0, 8'd60, 8'd1);
      seg_end();

      // Brake mid-segment
      issue(1'b0, 8'd70, 8'd0, 8'd10);
      word(1'b1, 1'b0, 1'b1, 1'b0, 8'd70, 8'd10);
      brake_clk = 1'b1;
      #1;
      chk("brake_wrreq", wrreq, 1'b0);
      @(posedge clk); #1;
      brake_clk = 1'b0;
      #1;
      chk("brake_err", err, 1'b0);
      chk("brake_busy", busy, 1'b0);
      chk("brake_no_done", done, 1'b0);

      // Abort and brake together
      @(posedge clk); #1;
      issue(1'b1, 8'd80, 8'd0, 8'd10);
      abort = 1'b1; brake_clk = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0; brake_clk = 1'b0;
      #1;
      chk("both_err", err, 1'b1);
      chk("both_busy", busy, 1'b0);
      issue(1'b0, 8'd9, 8'd0, 8'd0);
      word(1'b1, 1'b1, 1'b0, 1'b0, 8'd9, 8'd1);
      seg_end();

      // Async reset mid-segment
      issue(1'b1, 8'd90, 8'd0, 8'd10);
      word(1'b1, 1'b0, 1'b1, 1'b1, 8'd90, 8'd10);
      aclr = 1'b1;
      #1;
      chk("aclr_ready", cmd_ready, 1'b1);
      chk("aclr_busy", busy, 1'b0);
      chk("aclr_wrreq", wrreq, 1'b0);
      chk("aclr_T", pls_T, 8'd0);
      chk("aclr_steps", steps_left, 8'd0);
      chk("aclr_flags", {sop, eop, pls_mask, pls_dir, done, err}, 6'd0);
      aclr = 1'b0;
      @(posedge clk); #1;
      issue(1'b0, 8'd12, 8'd3, 8'd2);
      word(1'b1, 1'b0, 1'b1, 1'b0, 8'd12, 8'd2);
      word(1'b0, 1'b1, 1'b1, 1'b0, 8'd15, 8'd1);
      seg_end();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
